// File: rtl/tl_mips_pkg.sv
// Shared definitions for the MIPS MEM-stage load/store unit: MEM control bit
// positions, access FSM state, access sizes and byte-lane helpers.
package tl_mips_pkg;

  localparam int unsigned MEM_BNE      = 8;
  localparam int unsigned MEM_SB       = 7;
  localparam int unsigned MEM_SH       = 6;
  localparam int unsigned MEM_LB       = 5;
  localparam int unsigned MEM_LH       = 4;
  localparam int unsigned MEM_UNSIGNED = 3;
  localparam int unsigned MEM_BRANCH   = 2;
  localparam int unsigned MEM_READ     = 1;
  localparam int unsigned MEM_WRITE    = 0;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_LO_HALF = 4'b0011;
  localparam logic [3:0] BE_HI_HALF = 4'b1100;
  localparam logic [3:0] BE_ALL     = 4'b1111;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } access_size_e;

  // Lanes touched by an access; the offset bits below the access size are
  // ignored, which is what forces unchecked accesses to their aligned slot.
  function automatic logic [3:0] byte_enable(access_size_e sz, logic [1:0] off);
    case (sz)
      SZ_BYTE: return BE_BYTE0 << off;
      SZ_HALF: return off[1] ? BE_HI_HALF : BE_LO_HALF;
      default: return BE_ALL;
    endcase
  endfunction

  function automatic logic is_misaligned(access_size_e sz, logic [1:0] off);
    case (sz)
      SZ_HALF: return off[0];
      SZ_WORD: return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/tl_memory_lsu_if.sv
// EX/MEM -> MEM/WB bundle of the load/store unit, plus the debug read port.
// The LSU side is the slave modport; the pipeline/bench side is the master.
interface tl_memory_lsu_if #(
  parameter int unsigned LEN                  = 32,
  parameter int unsigned NB_CTRL_WB           = 2,
  parameter int unsigned NB_CTRL_MEM          = 9,
  parameter int unsigned NB_ADDRESS_REGISTROS = 5
);
  logic                            i_valid;
  logic [LEN-1:0]                  i_address;
  logic [LEN-1:0]                  i_write_data;
  logic [NB_CTRL_WB-1:0]           i_ctrl_wb;
  logic [NB_CTRL_MEM-1:0]          i_ctrl_mem;
  logic                            i_alu_zero;
  logic [NB_ADDRESS_REGISTROS-1:0] i_write_reg;
  logic [LEN-1:0]                  i_debug_addr;

  logic                            o_stall;
  logic                            o_valid;
  logic [LEN-1:0]                  o_address;
  logic [LEN-1:0]                  o_read_data;
  logic [NB_ADDRESS_REGISTROS-1:0] o_write_reg;
  logic [NB_CTRL_WB-1:0]           o_ctrl_wb;
  logic                            o_misaligned;
  logic                            o_PCSrc;
  logic [LEN-1:0]                  o_mem_reco;

  modport slave (
    input  i_valid, i_address, i_write_data, i_ctrl_wb, i_ctrl_mem,
           i_alu_zero, i_write_reg, i_debug_addr,
    output o_stall, o_valid, o_address, o_read_data, o_write_reg,
           o_ctrl_wb, o_misaligned, o_PCSrc, o_mem_reco
  );

  modport master (
    output i_valid, i_address, i_write_data, i_ctrl_wb, i_ctrl_mem,
           i_alu_zero, i_write_reg, i_debug_addr,
    input  o_stall, o_valid, o_address, o_read_data, o_write_reg,
           o_ctrl_wb, o_misaligned, o_PCSrc, o_mem_reco
  );
endinterface

// File: rtl/ram_datos_be.sv
// Data memory: RAM_DEPTH words with a byte-enable synchronous write port,
// a combinational read port and a combinational debug read port.
module ram_datos_be #(
  parameter int unsigned RAM_DEPTH = 2048,
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned AW        = $clog2(RAM_DEPTH)
) (
  input  logic             i_clk,
  input  logic [3:0]       i_we,
  input  logic [AW-1:0]    i_addr,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  input  logic [AW-1:0]    i_dbg_addr,
  output logic [WIDTH-1:0] o_dbg_data
);

  logic [WIDTH-1:0] r_mem [RAM_DEPTH];

  // NOTE: the storage array takes no reset; a reset port would stop it
  // mapping onto RAM macros and would also wipe memory on a pipeline reset.
  always_ff @(posedge i_clk) begin
    for (int b = 0; b < 4; b++) begin
      if (i_we[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
    end
  end

  assign o_rdata    = r_mem[i_addr];
  assign o_dbg_data = r_mem[i_dbg_addr];

endmodule

// File: rtl/tl_memory_lsu.sv
// MIPS MEM stage load/store unit with byte-lane stores, sub-word loads and a
// wait-state access FSM. Define LSU_MISALIGN_CHECK_EN to flag misaligned accesses.
module tl_memory_lsu
  import tl_mips_pkg::*;
#(
  parameter int unsigned LEN                  = 32,
  parameter int unsigned NB_CTRL_WB           = 2,
  parameter int unsigned NB_CTRL_MEM          = 9,
  parameter int unsigned NB_ADDRESS_REGISTROS = 5,
  parameter int unsigned RAM_DEPTH            = 2048,
  parameter int unsigned WAIT_STATES          = 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  tl_memory_lsu_if.slave bus
);

  localparam int unsigned AW       = $clog2(RAM_DEPTH);
  localparam bit          HAS_WAIT = (WAIT_STATES != 0);
  localparam logic [3:0]  WS_LOAD  = 4'(HAS_WAIT ? WAIT_STATES - 1 : 0);

  lsu_state_e                      r_state;
  logic [3:0]                      r_cnt;
  logic                            r_valid;
  logic [LEN-1:0]                  r_address;
  logic [LEN-1:0]                  r_read_data;
  logic [NB_ADDRESS_REGISTROS-1:0] r_write_reg;
  logic [NB_CTRL_WB-1:0]           r_ctrl_wb;
  logic                            r_misaligned;

  logic [NB_CTRL_MEM-1:0] w_ctrl;
  logic                   w_is_load;
  logic                   w_is_store;
  logic                   w_memop;
  logic                   w_stall;
  logic                   w_misaligned;
  access_size_e           w_size;
  logic [1:0]             w_offset;
  logic [AW-1:0]          w_word_idx;
  logic [3:0]             w_we;
  logic [LEN-1:0]         w_store_data;
  logic [LEN-1:0]         w_rword;
  logic [LEN-1:0]         w_shifted;
  logic [7:0]             w_byte;
  logic [15:0]            w_half;
  logic [LEN-1:0]         w_load_data;

  assign w_ctrl     = bus.i_ctrl_mem;
  assign w_is_load  = bus.i_valid & w_ctrl[MEM_READ];
  assign w_is_store = bus.i_valid & w_ctrl[MEM_WRITE];
  assign w_memop    = w_is_load | w_is_store;
  assign w_offset   = bus.i_address[1:0];
  assign w_word_idx = bus.i_address[AW+1:2];

  always_comb begin
    if (w_ctrl[MEM_READ]) begin
      w_size = w_ctrl[MEM_LB] ? SZ_BYTE : (w_ctrl[MEM_LH] ? SZ_HALF : SZ_WORD);
    end else begin
      w_size = w_ctrl[MEM_SB] ? SZ_BYTE : (w_ctrl[MEM_SH] ? SZ_HALF : SZ_WORD);
    end
  end

`ifdef LSU_MISALIGN_CHECK_EN
  assign w_misaligned = w_memop & is_misaligned(w_size, w_offset);
`else
  assign w_misaligned = 1'b0;
`endif

  // Store data is replicated across lanes so the byte enables alone pick the slot.
  always_comb begin
    unique case (w_size)
      SZ_BYTE: w_store_data = {4{bus.i_write_data[7:0]}};
      SZ_HALF: w_store_data = {2{bus.i_write_data[15:0]}};
      default: w_store_data = bus.i_write_data;
    endcase
  end

  assign w_stall = (r_state == ST_IDLE) ? (w_memop & HAS_WAIT) : (r_cnt != 4'd0);
  assign w_we    = (!w_stall && w_is_store && !w_misaligned) ? byte_enable(w_size, w_offset)
                                                             : BE_NONE;

  ram_datos_be #(
    .RAM_DEPTH (RAM_DEPTH),
    .WIDTH     (LEN)
  ) u_ram (
    .i_clk      (i_clk),
    .i_we       (w_we),
    .i_addr     (w_word_idx),
    .i_wdata    (w_store_data),
    .o_rdata    (w_rword),
    .i_dbg_addr (bus.i_debug_addr[AW-1:0]),
    .o_dbg_data (bus.o_mem_reco)
  );

  assign w_shifted = w_rword >> {w_offset, 3'b000};
  assign w_byte    = w_shifted[7:0];
  assign w_half    = w_offset[1] ? w_rword[31:16] : w_rword[15:0];

  // NOTE: every output of this block gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_load_data = '0;
    if (w_is_load && !w_misaligned) begin
      unique case (w_size)
        SZ_BYTE: w_load_data = w_ctrl[MEM_UNSIGNED] ? {{(LEN-8){1'b0}}, w_byte}
                                                    : {{(LEN-8){w_byte[7]}}, w_byte};
        SZ_HALF: w_load_data = w_ctrl[MEM_UNSIGNED] ? {{(LEN-16){1'b0}}, w_half}
                                                    : {{(LEN-16){w_half[15]}}, w_half};
        default: w_load_data = w_rword;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 4'd0;
      r_valid      <= 1'b0;
      r_address    <= '0;
      r_read_data  <= '0;
      r_write_reg  <= '0;
      r_ctrl_wb    <= '0;
      r_misaligned <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_memop && HAS_WAIT) begin
            r_state <= ST_WAIT;
            r_cnt   <= WS_LOAD;
          end
        end
        ST_WAIT: begin
          if (r_cnt != 4'd0) r_cnt   <= r_cnt - 4'd1;
          else               r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_stall) begin
        r_valid      <= 1'b0;
        r_misaligned <= 1'b0;
      end else begin
        r_valid      <= bus.i_valid;
        r_address    <= bus.i_address;
        r_read_data  <= w_load_data;
        r_write_reg  <= bus.i_write_reg;
        r_ctrl_wb    <= w_misaligned ? '0 : bus.i_ctrl_wb;
        r_misaligned <= w_misaligned;
      end
    end
  end

  assign bus.o_stall      = w_stall;
  assign bus.o_valid      = r_valid;
  assign bus.o_address    = r_address;
  assign bus.o_read_data  = r_read_data;
  assign bus.o_write_reg  = r_write_reg;
  assign bus.o_ctrl_wb    = r_ctrl_wb;
  assign bus.o_misaligned = r_misaligned;
  assign bus.o_PCSrc      = bus.i_valid & w_ctrl[MEM_BRANCH] &
                            (w_ctrl[MEM_BNE] ? ~bus.i_alu_zero : bus.i_alu_zero);

endmodule
